// File: rtl/eeg_demo_pkg.sv
// Shared types and constants for the EEG demo sequencer: FSM states,
// per-class sample bases and the expected-label rule for a vector index.
package eeg_demo_pkg;

   typedef enum logic [2:0] {IDLE, STREAM, WAIT_RES, SHOW, ERROR} state_t;

   localparam logic [15:0] SEIZURE_BASE = 16'h0100;
   localparam logic [15:0] NORMAL_BASE  = 16'h0200;

   // Even vector indices are the seizure recordings.
   function automatic logic expected_label(input logic [31:0] vid);
      return ~vid[0];
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front end: 2-FF synchroniser, stability-count debounce and a
// one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          level;

   // cnt counts consecutive cycles the synchronised input differs from level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[0], btn};
         pulse <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync[1];
            pulse <= sync[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/eeg_demo_sequencer.sv
// Demo front end for the seizure detector: streams a generated test vector,
// waits for the classification and drives LEDs/tallies. Optional label check
// is enabled by defining EEG_LABEL_CHECK_EN.
module eeg_demo_sequencer
   import eeg_demo_pkg::*;
#(
   parameter int DATA_WIDTH      = 16,
   parameter int FEATURE_COUNT   = 178,
   parameter int NUM_VECTORS     = 10,
   parameter int SEL_WIDTH       = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 4096,
   parameter int HOLD_CYCLES     = 1024,
   parameter int CNT_WIDTH       = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SEL_WIDTH-1:0]  vector_sel,
   input  logic                  start_btn,
   input  logic                  auto_mode,
   output logic [DATA_WIDTH-1:0] sample_data,
   output logic                  sample_valid,
   input  logic                  sample_ready,
   output logic                  sample_last,
   input  logic                  det_result_valid,
   input  logic                  det_seizure,
   output logic                  seizure_led,
   output logic                  non_seizure_led,
   output logic                  busy_led,
   output logic                  ready_led,
   output logic                  error_led,
   output logic [SEL_WIDTH-1:0]  vector_leds,
   output logic [CNT_WIDTH-1:0]  run_count,
   output logic [CNT_WIDTH-1:0]  seizure_count,
   output logic [CNT_WIDTH-1:0]  mismatch_count
);

   localparam int IW = $clog2(FEATURE_COUNT + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   state_t               state, state_n;
   logic [SEL_WIDTH-1:0] sel_meta, sel_sync, vid, vid_n;
   logic                 auto_meta, auto_sync, start_pulse;
   logic [IW-1:0]        idx, idx_n;
   logic [TW-1:0]        tcnt, tcnt_n;
   logic [HW-1:0]        hcnt, hcnt_n;
   logic                 result, result_n, res_evt, trig, mis_evt;
   logic [DATA_WIDTH-1:0] base;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (start_btn),
      .pulse (start_pulse)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_meta  <= '0;
         sel_sync  <= '0;
         auto_meta <= 1'b0;
         auto_sync <= 1'b0;
      end else begin
         sel_meta  <= vector_sel;
         sel_sync  <= sel_meta;
         auto_meta <= auto_mode;
         auto_sync <= auto_meta;
      end
   end

   // Stream outputs decode straight from state so reset drops valid at once.
   assign base         = vid[0] ? DATA_WIDTH'(NORMAL_BASE) : DATA_WIDTH'(SEIZURE_BASE);
   assign sample_valid = (state == STREAM);
   assign sample_last  = sample_valid && (idx == IW'(FEATURE_COUNT - 1));
   assign sample_data  = sample_valid ? (base + DATA_WIDTH'(idx) + DATA_WIDTH'(vid >> 1)) : '0;
   assign vector_leds  = vid;

   always_comb begin
      state_n  = state;
      vid_n    = vid;
      idx_n    = idx;
      tcnt_n   = tcnt;
      hcnt_n   = hcnt;
      result_n = result;
      res_evt  = 1'b0;
      trig     = 1'b0;
      unique case (state)
         IDLE: trig = start_pulse | auto_sync;
         STREAM: begin
            if (sample_ready) begin
               idx_n = idx + 1'b1;
               if (sample_last) begin
                  state_n = WAIT_RES;
                  tcnt_n  = '0;
               end
            end
         end
         WAIT_RES: begin
            tcnt_n = tcnt + 1'b1;
            if (det_result_valid) begin
               res_evt  = 1'b1;
               result_n = det_seizure;
               hcnt_n   = '0;
               state_n  = SHOW;
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
               state_n = ERROR;
            end
         end
         SHOW: begin
            if (auto_sync) begin
               hcnt_n = hcnt + 1'b1;
               if (hcnt == HW'(HOLD_CYCLES - 1)) begin
                  vid_n   = (32'(vid) == NUM_VECTORS - 1) ? '0 : vid + 1'b1;
                  idx_n   = '0;
                  state_n = STREAM;
               end
            end else begin
               trig = start_pulse;
            end
         end
         ERROR: if (start_pulse) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (trig) begin
         vid_n   = sel_sync;
         idx_n   = '0;
         state_n = (32'(sel_sync) >= NUM_VECTORS) ? ERROR : STREAM;
      end
   end

`ifdef EEG_LABEL_CHECK_EN
   assign mis_evt = res_evt && (det_seizure != expected_label(32'(vid)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           mismatch_count <= '0;
      else if (mis_evt && mismatch_count != '1) mismatch_count <= mismatch_count + 1'b1;
   end
`else
   assign mis_evt        = 1'b0;
   assign mismatch_count = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         vid             <= '0;
         idx             <= '0;
         tcnt            <= '0;
         hcnt            <= '0;
         result          <= 1'b0;
         run_count       <= '0;
         seizure_count   <= '0;
         ready_led       <= 1'b0;
         busy_led        <= 1'b0;
         error_led       <= 1'b0;
         seizure_led     <= 1'b0;
         non_seizure_led <= 1'b0;
      end else begin
         state  <= state_n;
         vid    <= vid_n;
         idx    <= idx_n;
         tcnt   <= tcnt_n;
         hcnt   <= hcnt_n;
         result <= result_n;
         if (res_evt && run_count != '1)                 run_count     <= run_count + 1'b1;
         if (res_evt && det_seizure && seizure_count != '1) seizure_count <= seizure_count + 1'b1;
         // LEDs follow the next state so they line up with the FSM.
         ready_led       <= (state_n == IDLE);
         busy_led        <= (state_n == STREAM) || (state_n == WAIT_RES);
         error_led       <= (state_n == ERROR) || mis_evt;
         seizure_led     <= (state_n == SHOW) && result_n;
         non_seizure_led <= (state_n == SHOW) && !result_n;
      end
   end

endmodule

// File: tb/tb_eeg_demo_sequencer.sv
// Directed bench for eeg_demo_sequencer: manual runs, backpressure, timeout,
// invalid select, glitch rejection, auto cycling with saturation, async reset.
module tb_eeg_demo_sequencer;

   localparam int DW = 16, FC = 178, NV = 10, SW = 4, DB = 16, TO = 4096, HOLD = 16, CW = 8;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic [SW-1:0] vector_sel = '0;
   logic          start_btn = 1'b0, auto_mode = 1'b0, sample_ready = 1'b1;
   logic          det_result_valid = 1'b0, det_seizure = 1'b0;
   logic [DW-1:0] sample_data;
   logic          sample_valid, sample_last;
   logic          seizure_led, non_seizure_led, busy_led, ready_led, error_led;
   logic [SW-1:0] vector_leds;
   logic [CW-1:0] run_count, seizure_count, mismatch_count;

   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   eeg_demo_sequencer #(
      .DATA_WIDTH(DW), .FEATURE_COUNT(FC), .NUM_VECTORS(NV), .SEL_WIDTH(SW),
      .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO), .HOLD_CYCLES(HOLD), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .vector_sel(vector_sel), .start_btn(start_btn),
      .auto_mode(auto_mode), .sample_data(sample_data), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .sample_last(sample_last),
      .det_result_valid(det_result_valid), .det_seizure(det_seizure),
      .seizure_led(seizure_led), .non_seizure_led(non_seizure_led), .busy_led(busy_led),
      .ready_led(ready_led), .error_led(error_led), .vector_leds(vector_leds),
      .run_count(run_count), .seizure_count(seizure_count), .mismatch_count(mismatch_count)
   );

   // Handshake monitor, sampling mid-cycle; inputs change just after posedge.
   logic [DW-1:0] cap_data[$];
   bit            cap_last[$];
   logic [DW-1:0] held_d;
   logic          held_l;
   bit            held = 0;
   int            stall_viol = 0, valid_cycles = 0;

   always @(negedge clk) begin
      if (sample_valid) begin
         valid_cycles++;
         if (held && (sample_data !== held_d || sample_last !== held_l)) stall_viol++;
         if (sample_ready) begin
            cap_data.push_back(sample_data);
            cap_last.push_back(sample_last);
            held = 0;
         end else begin
            held   = 1;
            held_d = sample_data;
            held_l = sample_last;
         end
      end else begin
         held = 0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Press long enough to debounce, release, and let the release settle.
   task automatic press();
      start_btn = 1'b1;
      tick(24);
      start_btn = 1'b0;
      tick(30);
   endtask

   task automatic wait_beats(input int start, input int n, input int budget, input bit toggle,
                             output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         tick(1);
         if (cap_data.size() >= start + n) begin
            ok = 1;
            break;
         end
         if (toggle) sample_ready = ~sample_ready;
      end
      sample_ready = 1'b1;
   endtask

   task automatic pulse_result(input logic seiz);
      det_seizure      = seiz;
      det_result_valid = 1'b1;
      tick(1);
      det_result_valid = 1'b0;
   endtask

   task automatic test_reset();
      tick(3);
      checks++; if ({sample_valid, sample_last, seizure_led, non_seizure_led, busy_led, ready_led, error_led} !== 7'b0) begin
         errors++; $display("FAIL reset_flags: got %b expected 0000000", {sample_valid, sample_last, seizure_led, non_seizure_led, busy_led, ready_led, error_led});
      end
      checks++; if ({sample_data, vector_leds, run_count, seizure_count, mismatch_count} !== '0) begin
         errors++; $display("FAIL reset_buses: data=%h vec=%h run=%0d seiz=%0d mis=%0d expected all 0", sample_data, vector_leds, run_count, seizure_count, mismatch_count);
      end
      rst_n = 1'b1;
      #1;
      checks++; if (ready_led !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b expected 0", ready_led); end
      tick(1);
      checks++; if (ready_led !== 1'b1 || busy_led !== 1'b0) begin
         errors++; $display("FAIL ready_after_reset: ready=%b busy=%b expected 1 0", ready_led, busy_led);
      end
   endtask

   task automatic test_manual();
      int st, nlast;
      bit ok;
      vector_sel = 4'd3;
      st = cap_data.size();
      press();
      wait_beats(st, FC, 400, 0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL manual_beats_timeout: got %0d beats expected %0d", cap_data.size() - st, FC); return; end
      tick(3);
      checks++; if (cap_data.size() - st !== FC) begin errors++; $display("FAIL manual_beat_count: got %0d expected %0d", cap_data.size() - st, FC); end
      checks++; if (cap_data[st] !== 16'h0201) begin errors++; $display("FAIL manual_first: got %h expected 0201", cap_data[st]); end
      checks++; if (cap_data[st+FC-1] !== 16'h02B2) begin errors++; $display("FAIL manual_final: got %h expected 02b2", cap_data[st+FC-1]); end
      nlast = 0;
      for (int k = 0; k < FC; k++) nlast += int'(cap_last[st+k]);
      checks++; if (nlast !== 1 || cap_last[st+FC-1] !== 1'b1) begin
         errors++; $display("FAIL manual_last: got %0d lasts, final=%b expected 1 and 1", nlast, cap_last[st+FC-1]);
      end
      checks++; if (busy_led !== 1'b1) begin errors++; $display("FAIL manual_busy_wait: got %b expected 1", busy_led); end
      pulse_result(1'b0);
      checks++; if ({non_seizure_led, seizure_led, busy_led} !== 3'b100) begin
         errors++; $display("FAIL manual_leds: got ns/s/busy=%b expected 100", {non_seizure_led, seizure_led, busy_led});
      end
      checks++; if (run_count !== 8'd1 || seizure_count !== 8'd0 || vector_leds !== 4'd3) begin
         errors++; $display("FAIL manual_counts: run=%0d seiz=%0d vec=%0d expected 1 0 3", run_count, seizure_count, vector_leds);
      end
   endtask

   task automatic test_backpressure();
      int st, sv;
      bit ok;
      vector_sel   = 4'd4;
      sample_ready = 1'b0;
      st = cap_data.size();
      sv = stall_viol;
      press();
      wait_beats(st, FC, 800, 1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_beats_timeout: got %0d beats expected %0d", cap_data.size() - st, FC); return; end
      tick(3);
      checks++; if (cap_data.size() - st !== FC) begin errors++; $display("FAIL bp_beat_count: got %0d expected %0d", cap_data.size() - st, FC); end
      checks++; if (cap_data[st] !== 16'h0102 || cap_data[st+FC-1] !== 16'h01B3) begin
         errors++; $display("FAIL bp_data: first=%h final=%h expected 0102 01b3", cap_data[st], cap_data[st+FC-1]);
      end
      checks++; if (stall_viol - sv !== 0) begin errors++; $display("FAIL bp_stable: got %0d stall changes expected 0", stall_viol - sv); end
      pulse_result(1'b1);
      checks++; if ({seizure_led, non_seizure_led} !== 2'b10 || run_count !== 8'd2 || seizure_count !== 8'd1) begin
         errors++; $display("FAIL bp_result: s/ns=%b run=%0d seiz=%0d expected 10 2 1", {seizure_led, non_seizure_led}, run_count, seizure_count);
      end
   endtask

   task automatic test_timeout();
      int st;
      bit ok;
      vector_sel = 4'd5;
      st = cap_data.size();
      press();
      wait_beats(st, FC, 400, 0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL to_beats_timeout: got %0d beats expected %0d", cap_data.size() - st, FC); return; end
      tick(TO - 1);
      checks++; if (error_led !== 1'b0 || busy_led !== 1'b1) begin
         errors++; $display("FAIL to_early: err=%b busy=%b expected 0 1", error_led, busy_led);
      end
      tick(1);
      checks++; if ({error_led, busy_led, seizure_led, non_seizure_led} !== 4'b1000) begin
         errors++; $display("FAIL to_error: err/busy/s/ns=%b expected 1000", {error_led, busy_led, seizure_led, non_seizure_led});
      end
      press();
      checks++; if (ready_led !== 1'b1 || error_led !== 1'b0) begin
         errors++; $display("FAIL to_recover: ready=%b err=%b expected 1 0", ready_led, error_led);
      end
   endtask

   task automatic test_invalid_sel();
      int vc;
      vector_sel = 4'd12;
      vc = valid_cycles;
      press();
      checks++; if (error_led !== 1'b1 || ready_led !== 1'b0 || vector_leds !== 4'd12) begin
         errors++; $display("FAIL inv_error: err=%b ready=%b vec=%0d expected 1 0 12", error_led, ready_led, vector_leds);
      end
      checks++; if (valid_cycles - vc !== 0) begin errors++; $display("FAIL inv_no_valid: got %0d valid cycles expected 0", valid_cycles - vc); end
      press();
      checks++; if (ready_led !== 1'b1 || error_led !== 1'b0) begin
         errors++; $display("FAIL inv_recover: ready=%b err=%b expected 1 0", ready_led, error_led);
      end
   endtask

   task automatic test_glitch();
      int vc;
      vector_sel = 4'd2;
      vc = valid_cycles;
      start_btn = 1'b1;
      tick(3);
      start_btn = 1'b0;
      tick(40);
      checks++; if (ready_led !== 1'b1 || busy_led !== 1'b0 || valid_cycles - vc !== 0) begin
         errors++; $display("FAIL glitch: ready=%b busy=%b valid_cycles=%0d expected 1 0 0", ready_led, busy_led, valid_cycles - vc);
      end
   endtask

   task automatic test_auto();
      int st;
      bit ok;
      vector_sel   = 4'd9;
      sample_ready = 1'b1;
      auto_mode    = 1'b1;
      for (int k = 0; k < 300; k++) begin
         st = cap_data.size();
         wait_beats(st, FC, 400, 0, ok);
         if (!ok) begin
            checks++; errors++;
            $display("FAIL auto_beats_timeout: run %0d got %0d beats expected %0d", k, cap_data.size() - st, FC);
            break;
         end
         pulse_result(1'b1);
         if (k == 0) begin
            checks++; if (cap_data[st] !== 16'h0204 || vector_leds !== 4'd9) begin
               errors++; $display("FAIL auto_first_run: data=%h vec=%0d expected 0204 9", cap_data[st], vector_leds);
            end
            checks++; if (run_count !== 8'd3 || seizure_count !== 8'd2) begin
               errors++; $display("FAIL auto_counts0: run=%0d seiz=%0d expected 3 2", run_count, seizure_count);
            end
            tick(HOLD - 1);
            checks++; if (busy_led !== 1'b0 || seizure_led !== 1'b1) begin
               errors++; $display("FAIL auto_hold: busy=%b seiz_led=%b expected 0 1", busy_led, seizure_led);
            end
            tick(1);
            checks++; if (busy_led !== 1'b1 || vector_leds !== 4'd0) begin
               errors++; $display("FAIL auto_wrap: busy=%b vec=%0d expected 1 0", busy_led, vector_leds);
            end
         end
         if (k == 1) begin
            checks++; if (cap_data[st] !== 16'h0100) begin errors++; $display("FAIL auto_vid0_first: got %h expected 0100", cap_data[st]); end
         end
      end
      checks++; if (run_count !== 8'd255 || seizure_count !== 8'd255) begin
         errors++; $display("FAIL auto_saturate: run=%0d seiz=%0d expected 255 255", run_count, seizure_count);
      end
`ifndef EEG_LABEL_CHECK_EN
      checks++; if (mismatch_count !== 8'd0) begin errors++; $display("FAIL mismatch_tied: got %0d expected 0", mismatch_count); end
`endif
   endtask

   task automatic test_async_reset();
      bit seen = 0;
      for (int i = 0; i < 400; i++) begin
         if (sample_valid === 1'b1) begin seen = 1; break; end
         tick(1);
      end
      checks++; if (!seen) begin errors++; $display("FAIL areset_stream_timeout: got valid=%b expected 1", sample_valid); return; end
      rst_n = 1'b0;
      #1;
      checks++; if (sample_valid !== 1'b0 || sample_data !== 16'h0000) begin
         errors++; $display("FAIL areset_valid_drop: valid=%b data=%h expected 0 0000", sample_valid, sample_data);
      end
      tick(1);
      checks++; if (run_count !== 8'd0 || busy_led !== 1'b0 || vector_leds !== 4'd0) begin
         errors++; $display("FAIL areset_state: run=%0d busy=%b vec=%0d expected 0 0 0", run_count, busy_led, vector_leds);
      end
      auto_mode = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);
      checks++; if (ready_led !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b expected 1", ready_led); end
   endtask

   initial begin
      test_reset();
      test_manual();
      test_backpressure();
      test_timeout();
      test_invalid_sel();
      test_glitch();
      test_auto();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
